// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU control codes, FSM state type, funct7/aluop encodings and decode.
// Latency: n/a (package). Backpressure: n/a.
// Optional feature macro ALU_MULDIV_EN: when defined, funct7 = 0000001 decodes to mul/div classes.
package alu_pkg;

  // 4-bit internal ALU control codes
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_MUL  = 4'b1100;
  localparam logic [3:0] ALU_DIV  = 4'b1101;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [1:0] AOP_MEM     = 2'b00;
  localparam logic [1:0] AOP_BRANCH  = 2'b01;
  localparam logic [1:0] AOP_RTYPE   = 2'b10;
  localparam logic [1:0] AOP_ILLEGAL = 2'b11;

  // funct3 values of the multiply class that need sign handling
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  typedef struct packed {
    logic [3:0] ctrl;
    logic       illegal;
  } alu_op_t;

  function automatic alu_op_t alu_decode(input logic [1:0] aluop,
                                         input logic [2:0] funct3,
                                         input logic [6:0] funct7);
    alu_op_t op;
    op.ctrl    = ALU_ADD;
    op.illegal = 1'b0;
    case (aluop)
      AOP_MEM:    op.ctrl = ALU_ADD;
      AOP_BRANCH: op.ctrl = ALU_SUB;
      AOP_RTYPE: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'd0:    op.ctrl = ALU_ADD;
            3'd1:    op.ctrl = ALU_SLL;
            3'd2:    op.ctrl = ALU_SLT;
            3'd3:    op.ctrl = ALU_SLTU;
            3'd4:    op.ctrl = ALU_XOR;
            3'd5:    op.ctrl = ALU_SRL;
            3'd6:    op.ctrl = ALU_OR;
            default: op.ctrl = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000)      op.ctrl    = ALU_SUB;
          else if (funct3 == 3'b101) op.ctrl    = ALU_SRA;
          else                       op.illegal = 1'b1;
`ifdef ALU_MULDIV_EN
        end else if (funct7 == F7_MULDIV) begin
          // funct3[2] splits mul group (0..3) from div group (4..7)
          op.ctrl = funct3[2] ? ALU_DIV : ALU_MUL;
`endif
        end else begin
          op.illegal = 1'b1;
        end
      end
      default: op.illegal = 1'b1;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: iterative shift-add multiplier / restoring divider on operand magnitudes.
// Latency: XLEN iterations after start; 'last' flags the final iteration cycle.
// Backpressure: none; result holds after completion until the next start. Built only under ALU_MULDIV_EN.
// Ports: clk, reset (sync, active-high), start, funct3, a, b in; last, result out.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            last,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  logic              busy_q, busy_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;          // sign of product or quotient
  logic              neg_rem_q, neg_rem_d;  // remainder follows the dividend sign
  logic              div0_q, div0_d;
  logic [XLEN-1:0]   mag_a_q, mag_a_d, mag_b_q, mag_b_d;
  // mul: full product; div: {remainder, quotient}
  logic [2*XLEN-1:0] acc_q, acc_d;

  logic              sign_a, sign_b;
  logic [XLEN:0]     rem_sh;
  logic [XLEN-1:0]   rem_sub;

  always_comb begin
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    f3_d      = f3_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    acc_d     = acc_q;
    sign_a    = 1'b0;
    sign_b    = 1'b0;
    rem_sh    = '0;
    rem_sub   = '0;
    if (start) begin
      if (funct3[2]) begin
        // div/rem are signed, divu/remu are not
        sign_a = !funct3[0] && a[XLEN-1];
        sign_b = !funct3[0] && b[XLEN-1];
      end else begin
        sign_a = (funct3 == F3_MULH || funct3 == F3_MULHSU) && a[XLEN-1];
        sign_b = (funct3 == F3_MULH) && b[XLEN-1];
      end
      busy_d    = 1'b1;
      cnt_d     = CW'(XLEN - 1);
      f3_d      = funct3;
      neg_d     = sign_a ^ sign_b;
      neg_rem_d = sign_a;
      div0_d    = (b == '0);
      mag_a_d   = sign_a ? -a : a;
      mag_b_d   = sign_b ? -b : b;
      acc_d     = '0;
    end else if (busy_q) begin
      if (f3_q[2]) begin
        // one restoring step: bring in the next dividend bit, MSB first
        rem_sh  = {acc_q[2*XLEN-1:XLEN], mag_a_q[cnt_q]};
        rem_sub = rem_sh[XLEN-1:0] - mag_b_q;
        if (rem_sh >= {1'b0, mag_b_q})
          acc_d = {rem_sub, acc_q[XLEN-2:0], 1'b1};
        else
          acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end else begin
        // MSB-first shift-add over the multiplier bits
        acc_d = {acc_q[2*XLEN-2:0], 1'b0}
              + (mag_b_q[cnt_q] ? {{XLEN{1'b0}}, mag_a_q} : {(2*XLEN){1'b0}});
      end
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      f3_q      <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      acc_q     <= '0;
    end else begin
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      f3_q      <= f3_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      mag_a_q   <= mag_a_d;
      mag_b_q   <= mag_b_d;
      acc_q     <= acc_d;
    end
  end

  // Sign fix-up. Signed overflow falls out naturally: |q| = 2^(XLEN-1), unnegated, equals a.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;
  assign prod = neg_q ? -acc_q : acc_q;
  assign quo  = div0_q ? {XLEN{1'b1}} : (neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]);
  assign rem  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  assign result = f3_q[2] ? (f3_q[1] ? rem : quo)
                          : ((f3_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  assign last   = busy_q && (cnt_q == '0);

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RISC-V ALU execute stage; decodes aluop/funct3/funct7 and computes on XLEN operands.
// Latency: 1 cycle after accept for single-cycle/illegal ops, XLEN+1 for mul/div (ALU_MULDIV_EN).
// Backpressure: in_ready high only in IDLE; result held with out_valid until out_ready.
// Ports: clk, reset (sync, active-high); in_valid/in_ready, aluop, funct3, funct7, a, b in;
//        out_valid/out_ready, result, zero, illegal out.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      aluop,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN);

  state_e          state_q;
  logic            in_ready_q, out_valid_q, zero_q, illegal_q;
  logic [XLEN-1:0] result_q, a_q, b_q;
  alu_op_t         op_q, dec_d;
  logic [XLEN-1:0] alu_res_d;
  logic            accept, is_md_d;

  assign accept  = in_valid && in_ready_q;
  assign dec_d   = alu_decode(aluop, funct3, funct7);
  assign is_md_d = !dec_d.illegal && (dec_d.ctrl == ALU_MUL || dec_d.ctrl == ALU_DIV);

`ifdef ALU_MULDIV_EN
  logic            md_last;
  logic [XLEN-1:0] md_result;

  // The iterator latches its own operands and funct3 on start.
  alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (accept && is_md_d),
    .funct3 (funct3),
    .a      (a),
    .b      (b),
    .last   (md_last),
    .result (md_result)
  );
`endif

  always_comb begin
    alu_res_d = '0;
    if (!op_q.illegal) begin
      case (op_q.ctrl)
        ALU_ADD:  alu_res_d = a_q + b_q;
        ALU_SUB:  alu_res_d = a_q - b_q;
        ALU_AND:  alu_res_d = a_q & b_q;
        ALU_OR:   alu_res_d = a_q | b_q;
        ALU_XOR:  alu_res_d = a_q ^ b_q;
        ALU_SLL:  alu_res_d = a_q << b_q[SHW-1:0];
        ALU_SRL:  alu_res_d = a_q >> b_q[SHW-1:0];
        ALU_SRA:  alu_res_d = $unsigned($signed(a_q) >>> b_q[SHW-1:0]);
        ALU_SLT:  alu_res_d = {{(XLEN-1){1'b0}}, $signed(a_q) < $signed(b_q)};
        ALU_SLTU: alu_res_d = {{(XLEN-1){1'b0}}, a_q < b_q};
`ifdef ALU_MULDIV_EN
        ALU_MUL, ALU_DIV: alu_res_d = md_result;
`endif
        default:  alu_res_d = '0;
      endcase
    end
  end

  // DONE spends one cycle registering the result before out_valid rises.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            op_q       <= dec_d;
            a_q        <= a;
            b_q        <= b;
            in_ready_q <= 1'b0;
            state_q    <= is_md_d ? CALC : DONE;
          end
        end
`ifdef ALU_MULDIV_EN
        CALC: if (md_last) state_q <= DONE;
`endif
        DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            result_q    <= alu_res_d;
            zero_q      <= (alu_res_d == '0);
            illegal_q   <= op_q.illegal;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: randomized + directed checks of alu_exec_unit against a behavioural model.
// Latency: model predicts 1 cycle (or XLEN+1 for mul/div when ALU_MULDIV_EN is defined).
// Backpressure: exercises out_ready stalls, drain timing and reset aborts.
module tb_alu_exec_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset, in_valid, in_ready, out_valid, out_ready, zero, illegal;
  logic [1:0]      aluop;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] a, b, result;

  int n_tests = 0;
  int n_fail  = 0;

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluop     (aluop),
    .funct3    (funct3),
    .funct7    (funct7),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference model written straight from the ISA semantics.
  function automatic void ref_alu(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [31:0] av, input logic [31:0] bv,
                                  output logic [31:0] r, output bit ill, output int lat);
    int          sa, sb;
    longint      p;
    logic [63:0] pu;
    sa  = av;
    sb  = bv;
    r   = 32'h0;
    ill = 1'b0;
    lat = 1;
    p   = 0;
    pu  = 64'h0;
    if (op == 2'b00)      r = av + bv;
    else if (op == 2'b01) r = av - bv;
    else if (op == 2'b11) ill = 1'b1;
    else if (f7 == 7'h00) begin
      case (f3)
        3'd0: r = av + bv;
        3'd1: r = av << bv[4:0];
        3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
        3'd3: r = (av < bv) ? 32'd1 : 32'd0;
        3'd4: r = av ^ bv;
        3'd5: r = av >> bv[4:0];
        3'd6: r = av | bv;
        default: r = av & bv;
      endcase
    end else if (f7 == 7'h20 && f3 == 3'd0) r = av - bv;
    else if (f7 == 7'h20 && f3 == 3'd5) r = sa >>> bv[4:0];
`ifdef ALU_MULDIV_EN
    else if (f7 == 7'h01) begin
      lat = XLEN + 1;
      case (f3)
        3'd0: r = av * bv;
        3'd1: begin p = longint'(sa) * longint'(sb); r = p[63:32]; end
        3'd2: begin p = longint'(sa) * longint'({32'h0, bv}); r = p[63:32]; end
        3'd3: begin pu = {32'h0, av} * {32'h0, bv}; r = pu[63:32]; end
        3'd4: if (bv == 0) r = 32'hFFFF_FFFF;
              else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) r = av;
              else r = sa / sb;
        3'd5: r = (bv == 0) ? 32'hFFFF_FFFF : av / bv;
        3'd6: if (bv == 0) r = av;
              else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) r = 32'h0;
              else r = sa % sb;
        default: r = (bv == 0) ? av : av % bv;
      endcase
    end
`endif
    else ill = 1'b1;
  endfunction

  task automatic do_op(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] av, input logic [31:0] bv, input int hold, input string tag);
    logic [31:0] er;
    bit          ei;
    int          el, cyc;
    ref_alu(op, f3, f7, av, bv, er, ei, el);
    cyc = 0;
    while (!in_ready && cyc < 100) begin @(negedge clk); cyc++; end
    check_eq({tag, "_rdy"}, in_ready, 1);
    aluop = op; funct3 = f3; funct7 = f7; a = av; b = bv; in_valid = 1'b1;
    @(negedge clk);
    // scramble inputs: they must be ignored while busy
    in_valid = 1'($urandom_range(0, 1));
    aluop = 2'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
    a = $urandom; b = $urandom;
    check_eq({tag, "_early"}, out_valid, 0);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!out_valid && cyc < 100);
    check_eq({tag, "_lat"}, cyc, el);
    check_eq({tag, "_res"}, result, er);
    check_eq({tag, "_zero"}, zero, (er == 0));
    check_eq({tag, "_ill"}, illegal, ei);
    check_eq({tag, "_irdy"}, in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq({tag, "_hold_vld"}, out_valid, 1);
      check_eq({tag, "_hold_res"}, result, er);
      check_eq({tag, "_hold_ill"}, illegal, ei);
      check_eq({tag, "_hold_irdy"}, in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "_drain_vld"}, out_valid, 0);
    check_eq({tag, "_drain_irdy"}, in_ready, 1);
  endtask

  task automatic reset_abort(input logic [6:0] f7, input int wait_cyc, input string tag);
    int cyc, seen;
    cyc = 0;
    while (!in_ready && cyc < 100) begin @(negedge clk); cyc++; end
    aluop = 2'b10; funct3 = 3'd0; funct7 = f7; a = 32'h1234_5678; b = 32'h9; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (wait_cyc) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq({tag, "_rst_irdy"}, in_ready, 0);
    check_eq({tag, "_rst_vld"}, out_valid, 0);
    check_eq({tag, "_rst_res"}, result, 0);
    @(negedge clk);
    check_eq({tag, "_post_irdy"}, in_ready, 1);
    seen = 0;
    repeat (40) begin @(negedge clk); if (out_valid) seen++; end
    check_eq({tag, "_no_vld"}, seen, 0);
  endtask

  initial begin
    logic [31:0] specials [6];
    logic [1:0]  rop;
    logic [2:0]  rf3;
    logic [6:0]  rf7;
    logic [31:0] ra, rb;
    specials = '{32'h0, 32'h1, 32'h7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    aluop = '0; funct3 = '0; funct7 = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_irdy", in_ready, 0);
    check_eq("reset_vld", out_valid, 0);
    check_eq("reset_res", result, 0);
    check_eq("reset_zero", zero, 0);
    check_eq("reset_ill", illegal, 0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("post_reset_irdy", in_ready, 1);

    do_op(2'b00, 3'd0, 7'h00, 32'h10, 32'h4, 0, "mem_add");
    do_op(2'b01, 3'd0, 7'h00, 32'h1234, 32'h1234, 0, "br_sub");
    do_op(2'b10, 3'd5, 7'h20, 32'h8000_0000, 32'h4, 0, "sra");
    do_op(2'b10, 3'd2, 7'h00, 32'hFFFF_FFFF, 32'h1, 0, "slt");
    do_op(2'b11, 3'd0, 7'h00, 32'h5, 32'h6, 0, "aop_ill");
    do_op(2'b10, 3'd1, 7'h20, 32'h5, 32'h6, 0, "f7alt_ill");
    do_op(2'b10, 3'd0, 7'h00, 32'hAAAA, 32'h5555, 5, "hold5");
`ifdef ALU_MULDIV_EN
    do_op(2'b10, 3'd1, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulh");
    do_op(2'b10, 3'd3, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu");
    do_op(2'b10, 3'd4, 7'h01, 32'h7, 32'h0, 0, "div0");
    do_op(2'b10, 3'd6, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");
    do_op(2'b10, 3'd4, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 3, "div_ovf");
    reset_abort(7'h01, 10, "abort_calc");
`else
    do_op(2'b10, 3'd0, 7'h01, 32'h3, 32'h4, 0, "md_ill");
`endif
    out_ready = 1'b0;
    reset_abort(7'h00, 3, "abort_done");

    for (int t = 0; t < 200; t++) begin
      rop = ($urandom_range(0, 9) < 7) ? 2'b10 : 2'($urandom);
      case ($urandom_range(0, 3))
        0:       rf7 = 7'h00;
        1:       rf7 = 7'h20;
        2:       rf7 = 7'h01;
        default: rf7 = 7'($urandom);
      endcase
      rf3 = 3'($urandom);
      ra  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      do_op(rop, rf3, rf7, ra, rb, $urandom_range(0, 2), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
